// File: rtl/alarm_timekeeper.sv
// 24-hour BCD time-of-day keeper with a settable hh:mm alarm and a ring/snooze/stop
// state machine, advanced by the externally divided seconds square wave.
module alarm_timekeeper #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       alarm_enable,
    input  logic       stop,
    input  logic       snooze,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       alarm_out,
    output logic [1:0] alarm_state,
    output logic       set_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RINGING = 2'b01,
        S_SNOOZE  = 2'b10
    } state_t;

    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [RW-1:0] RING_MAX = RW'(RING_TIMEOUT_SEC);
    localparam logic [SW-1:0] SNZ_MAX  = SW'(SNOOZE_SEC);

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [7:0]    r_hh;
    logic [7:0]    r_mm;
    logic [7:0]    r_ss;
    logic [7:0]    r_alm_hh;
    logic [7:0]    r_alm_mm;
    logic          r_sec_pulse;
    logic          r_set_err;
    logic          r_alarm_out;
    state_t        r_state;
    logic [RW-1:0] r_ring_cnt;
    logic [SW-1:0] r_snz_cnt;

    logic          w_tick;
    logic          w_hh_ok;
    logic          w_mm_ok;
    logic          w_set_ok;
    logic          w_load_time;
    logic          w_load_alarm;
    logic          w_set_bad;
    logic          w_ss_wrap;
    logic          w_mm_wrap;
    logic [7:0]    w_ss_inc;
    logic [7:0]    w_mm_inc;
    logic [7:0]    w_hh_inc;
    logic          w_match;
    state_t        w_state_nxt;
    logic [RW-1:0] w_ring_nxt;
    logic [SW-1:0] w_snz_nxt;
    logic [RW-1:0] w_ring_inc;
    logic [SW-1:0] w_snz_inc;

    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Only the rising edge of the synchronised square wave counts as a second.
    assign w_tick = r_s2 & ~r_s3;

    assign w_hh_ok = (set_hh[7:4] <= 4'd2) && (set_hh[3:0] <= 4'd9) &&
                     !((set_hh[7:4] == 4'd2) && (set_hh[3:0] > 4'd3));
    assign w_mm_ok = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
    assign w_set_ok     = w_hh_ok & w_mm_ok;
    assign w_load_time  = set_time & w_set_ok;
    assign w_load_alarm = set_alarm & w_set_ok;
    assign w_set_bad    = (set_time | set_alarm) & ~w_set_ok;

    assign w_ss_wrap = (r_ss == 8'h59);
    assign w_mm_wrap = (r_mm == 8'h59);

    always_comb begin
        w_ss_inc = w_ss_wrap ? 8'h00 : bcdInc(r_ss);
        w_mm_inc = r_mm;
        w_hh_inc = r_hh;
        if (w_ss_wrap) begin
            w_mm_inc = w_mm_wrap ? 8'h00 : bcdInc(r_mm);
            if (w_mm_wrap) begin
                w_hh_inc = (r_hh == 8'h23) ? 8'h00 : bcdInc(r_hh);
            end
        end
    end

    // A coincident set_time replaces the incremented time, so it can never cause a match.
    assign w_match = w_tick & ~w_load_time & alarm_enable & (r_state == S_IDLE) &
                     (w_hh_inc == r_alm_hh) & (w_mm_inc == r_alm_mm) & (w_ss_inc == 8'h00);

    assign w_ring_inc = (r_ring_cnt == RING_MAX) ? r_ring_cnt : r_ring_cnt + RW'(1);
    assign w_snz_inc  = (r_snz_cnt == SNZ_MAX)   ? r_snz_cnt  : r_snz_cnt + SW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
        w_snz_nxt   = r_snz_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_match) begin
                    w_state_nxt = S_RINGING;
                    w_ring_nxt  = '0;
                end
            end
            S_RINGING: begin
                if (!alarm_enable || stop) begin
                    w_state_nxt = S_IDLE;
                end else if (snooze) begin
                    w_state_nxt = S_SNOOZE;
                    w_snz_nxt   = '0;
                end else if (w_tick) begin
                    w_ring_nxt = w_ring_inc;
                    if (w_ring_inc == RING_MAX) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_SNOOZE: begin
                if (!alarm_enable || stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_snz_nxt = w_snz_inc;
                    if (w_snz_inc == SNZ_MAX) begin
                        w_state_nxt = S_RINGING;
                        w_ring_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ring_cnt  <= '0;
            r_snz_cnt   <= '0;
            r_alarm_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ring_cnt  <= w_ring_nxt;
            r_snz_cnt   <= w_snz_nxt;
            r_alarm_out <= (w_state_nxt == S_RINGING);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_hh        <= 8'h00;
            r_mm        <= 8'h00;
            r_ss        <= 8'h00;
            r_alm_hh    <= 8'h00;
            r_alm_mm    <= 8'h00;
            r_sec_pulse <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_s1        <= sec_in;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_sec_pulse <= w_tick;
            r_set_err   <= w_set_bad;
            if (w_load_time) begin
                r_hh <= set_hh;
                r_mm <= set_mm;
                r_ss <= 8'h00;
            end else if (w_tick) begin
                r_hh <= w_hh_inc;
                r_mm <= w_mm_inc;
                r_ss <= w_ss_inc;
            end
            if (w_load_alarm) begin
                r_alm_hh <= set_hh;
                r_alm_mm <= set_mm;
            end
        end
    end

    assign hh          = r_hh;
    assign mm          = r_mm;
    assign ss          = r_ss;
    assign sec_pulse   = r_sec_pulse;
    assign set_err     = r_set_err;
    assign alarm_out   = r_alarm_out;
    assign alarm_state = r_state;

endmodule
